axistream_pack_arbiter: RTL and testbench

//  Shares one narrow AXI-Stream feeding the axistream_pack datapath among NUM_SRC

---
 rtl/axis_pack_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/axistream_pack_arbiter.sv | 135 +++++++++++++
 tb/tb_axistream_pack_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pack_pkg.sv
// Shared definitions for the packet-granular AXI-Stream arbiter in front of the packer.
package axis_pack_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StPass = 2'd1,
      StPad  = 2'd2
   } state_e;

   localparam int unsigned PadTotalWidth = 16;

   // Index/counter width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, with wrap.
module rr_arbiter
   import axis_pack_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   localparam int unsigned IdxW = clog2_min1(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IdxW-1:0]    last_grant,
   output logic               any,
   output logic [IdxW-1:0]    grant_idx
);

   logic            found;
   logic [IdxW-1:0] cand;

   // Scan last_grant+1 .. last_grant+NUM_SRC so the last winner is checked last.
   always_comb begin
      any       = |req;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         cand = IdxW'((32'(last_grant) + k) % NUM_SRC);
         if (!found && req[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

endmodule

// File: rtl/axistream_pack_arbiter.sv
// Round-robin, packet-granular mux of NUM_SRC AXI-Stream sources onto one packer input.
// Short packet tails are padded with PAD_WORD so tlast only lands on beat k*NUM_PACK-1.
module axistream_pack_arbiter
   import axis_pack_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH = 8,
   parameter int unsigned          NUM_PACK   = 4,
   parameter int unsigned          NUM_SRC    = 4,
   parameter logic [DATA_WIDTH-1:0] PAD_WORD  = '0,
   localparam int unsigned         IdW        = clog2_min1(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC-1:0]            s_tvalid,
   output logic [NUM_SRC-1:0]            s_tready,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_SRC-1:0]            s_tlast,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [DATA_WIDTH-1:0]         m_tdata,
   output logic                          m_tlast,
   output logic [IdW-1:0]                m_tid,
   output logic                          pad_event,
   output logic [PadTotalWidth-1:0]      pad_total
);

   localparam int unsigned    CntW     = clog2_min1(NUM_PACK);
   localparam logic [CntW-1:0] LastBeat = CntW'(NUM_PACK - 1);
   localparam logic [CntW-1:0] PadBase  = CntW'(NUM_PACK - 2);

   state_e          state;
   logic [IdW-1:0]  grant;
   logic [IdW-1:0]  last_grant;
   logic [CntW-1:0] beat_cnt;
   logic [CntW-1:0] pad_left;

   logic                  arb_any;
   logic [IdW-1:0]        arb_idx;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  beat_acc;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_rr_arbiter (
      .req        (s_tvalid),
      .last_grant (last_grant),
      .any        (arb_any),
      .grant_idx  (arb_idx)
   );

   assign sel_valid = s_tvalid[grant];
   assign sel_last  = s_tlast[grant];
   assign sel_data  = s_tdata[32'(grant) * DATA_WIDTH +: DATA_WIDTH];
   assign beat_acc  = m_tvalid && m_tready;
   assign m_tid     = grant;

   // Output mux: zero-latency pass-through in PASS, self-sourced pad beats in PAD.
   always_comb begin
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tlast  = 1'b0;
      s_tready = '0;
      unique case (state)
         StPass: begin
            m_tvalid        = sel_valid;
            m_tdata         = sel_data;
            // A misaligned source tlast is swallowed; the pad tail carries it instead.
            m_tlast         = sel_last && (beat_cnt == LastBeat);
            s_tready[grant] = m_tready;
         end
         StPad: begin
            m_tvalid = 1'b1;
            m_tdata  = PAD_WORD;
            m_tlast  = (pad_left == '0);
         end
         default: ;
      endcase
   end

   // Arbitration FSM, beat/pad counters and pad statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         grant      <= '0;
         last_grant <= IdW'(NUM_SRC - 1);
         beat_cnt   <= '0;
         pad_left   <= '0;
         pad_event  <= 1'b0;
         pad_total  <= '0;
      end else begin
         pad_event <= 1'b0;
         unique case (state)
            StIdle: begin
               if (arb_any) begin
                  grant      <= arb_idx;
                  last_grant <= arb_idx;
                  state      <= StPass;
               end
            end
            StPass: begin
               if (beat_acc) begin
                  beat_cnt <= (beat_cnt == LastBeat) ? '0 : beat_cnt + 1'b1;
                  if (sel_last) begin
                     if (beat_cnt == LastBeat) begin
                        state <= StIdle;
                     end else begin
                        // pad_left counts remaining pad beats minus one; 0 marks the tlast beat.
                        pad_left  <= PadBase - beat_cnt;
                        pad_event <= 1'b1;
                        state     <= StPad;
                     end
                  end
               end
            end
            StPad: begin
               if (m_tready) begin
                  if (pad_total != '1) begin
                     pad_total <= pad_total + 1'b1;
                  end
                  if (pad_left == '0) begin
                     state    <= StIdle;
                     beat_cnt <= '0;
                  end else begin
                     pad_left <= pad_left - 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axistream_pack_arbiter.sv
// Bench for axistream_pack_arbiter: directed scenarios pinned with literals, then random
// traffic, all checked every cycle against a packet-level reference model.
module tb_axistream_pack_arbiter;

   localparam int unsigned DW   = 8;
   localparam int unsigned NP   = 4;
   localparam int unsigned NS   = 4;
   localparam int unsigned IW   = 2;
   localparam logic [7:0]  PADW = 8'hA5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NS-1:0]    s_tvalid = '0;
   logic [NS-1:0]    s_tready;
   logic [NS*DW-1:0] s_tdata = '0;
   logic [NS-1:0]    s_tlast = '0;
   logic             m_tvalid;
   logic             m_tready = 1'b1;
   logic [DW-1:0]    m_tdata;
   logic             m_tlast;
   logic [IW-1:0]    m_tid;
   logic             pad_event;
   logic [15:0]      pad_total;

   always #5 clk = ~clk;

   axistream_pack_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_PACK   (NP),
      .NUM_SRC    (NS),
      .PAD_WORD   (PADW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tdata   (s_tdata),
      .s_tlast   (s_tlast),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tdata   (m_tdata),
      .m_tlast   (m_tlast),
      .m_tid     (m_tid),
      .pad_event (pad_event),
      .pad_total (pad_total)
   );

   int total = 0;
   int bad   = 0;

   // Source side: per-source beat queues {last, data}; hold keeps valid up until accepted.
   logic [8:0] srcq [NS][$];
   bit         hold [NS];
   int         vprob = 100;
   int         rmode = 0;
   bit         tog = 1'b0;

   // Reference model: packet owner, beats sent so far, pad beats still owed.
   int mstate, owner, last_g, cnt, pad_rem, ptot;
   bit pev;
   bit ev, el;
   logic [7:0]    ed;
   logic [NS-1:0] er;

   int obeats = 0;
   int pev_seen = 0;
   typedef struct {
      int         tid;
      bit         last;
      logic [7:0] data;
   } beat_t;
   beat_t log_q[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mstate  = 0;
      owner   = 0;
      last_g  = NS - 1;
      cnt     = 0;
      pad_rem = 0;
      ptot    = 0;
      pev     = 1'b0;
   endfunction

   function automatic void model_out();
      ev = 1'b0;
      el = 1'b0;
      ed = '0;
      er = '0;
      if (mstate == 1) begin
         ev        = s_tvalid[owner];
         ed        = s_tdata[owner*DW +: DW];
         el        = s_tlast[owner] && ((cnt + 1) % NP == 0);
         er[owner] = m_tready;
      end else if (mstate == 2) begin
         ev = 1'b1;
         ed = PADW;
         el = (pad_rem == 1);
      end
   endfunction

   task automatic model_edge();
      bit found;
      int c;
      if (!rst_n) begin
         model_reset();
      end else begin
         case (mstate)
            0: begin
               pev   = 1'b0;
               found = 1'b0;
               for (int k = 1; k <= NS; k++) begin
                  c = (last_g + k) % NS;
                  if (!found && s_tvalid[c]) begin
                     found = 1'b1;
                     owner = c;
                  end
               end
               if (found) begin
                  last_g = owner;
                  mstate = 1;
                  cnt    = 0;
               end
            end
            1: begin
               pev = 1'b0;
               if (ev && m_tready) begin
                  void'(srcq[owner].pop_front());
                  hold[owner] = 1'b0;
                  cnt++;
                  if (s_tlast[owner]) begin
                     if (cnt % NP == 0) begin
                        mstate = 0;
                     end else begin
                        pad_rem = NP - (cnt % NP);
                        pev     = 1'b1;
                        mstate  = 2;
                     end
                  end
               end
            end
            default: begin
               pev = 1'b0;
               if (m_tready) begin
                  if (ptot < 65535) ptot++;
                  pad_rem--;
                  if (pad_rem == 0) mstate = 0;
               end
            end
         endcase
      end
   endtask

   task automatic drive();
      logic [8:0] h;
      tog = ~tog;
      case (rmode)
         0:       m_tready = 1'b1;
         1:       m_tready = tog;
         default: m_tready = ($urandom_range(0, 99) < 75);
      endcase
      for (int i = 0; i < NS; i++) begin
         if (!hold[i] && srcq[i].size() > 0 && $urandom_range(0, 99) < vprob) hold[i] = 1'b1;
         s_tvalid[i] = hold[i];
         h = hold[i] ? srcq[i][0] : 9'h0;
         s_tdata[i*DW +: DW] = h[7:0];
         s_tlast[i] = h[8];
      end
   endtask

   task automatic compare();
      model_out();
      chk("m_tvalid", int'(m_tvalid), int'(ev));
      chk("s_tready", int'(s_tready), int'(er));
      if (ev) begin
         chk("m_tdata", int'(m_tdata), int'(ed));
         chk("m_tlast", int'(m_tlast), int'(el));
      end
      chk("m_tid", int'(m_tid), owner);
      chk("pad_event", int'(pad_event), int'(pev));
      chk("pad_total", int'(pad_total), ptot);
      if (pad_event) pev_seen++;
      if (rst_n && m_tvalid && m_tready) begin
         log_q.push_back('{tid: int'(m_tid), last: m_tlast, data: m_tdata});
         obeats++;
         if (m_tlast) begin
            chk("tlast_align", obeats % NP, 0);
            obeats = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      drive();
      @(negedge clk);
      compare();
   endtask

   function automatic bit busy();
      bit b = (mstate != 0);
      for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) b = 1'b1;
      return b;
   endfunction

   task automatic drain(input int budget);
      int n = 0;
      while (busy() && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("drain_timeout", 1, 0);
      repeat (2) step();
   endtask

   task automatic push_pkt(input int s, input int len, input int base, input bit rnd);
      logic [7:0] d;
      for (int j = 0; j < len; j++) begin
         d = rnd ? 8'($urandom) : 8'(base + j);
         srcq[s].push_back({(j == len - 1), d});
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < NS; i++) begin
         srcq[i].delete();
         hold[i] = 1'b0;
      end
      obeats = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      clear_src();
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic chk_log(input string name, input int idx, input int tid, input bit last,
                          input int data);
      if (idx < log_q.size()) begin
         chk({name, "_tid"}, log_q[idx].tid, tid);
         chk({name, "_last"}, int'(log_q[idx].last), int'(last));
         chk({name, "_data"}, int'(log_q[idx].data), data);
      end else begin
         chk({name, "_missing"}, idx, -1);
      end
   endtask

   initial begin
      int exp3[5];
      int p;
      bit start;
      int n;
      int s;

      model_reset();
      drive();
      @(negedge clk);
      // Reset state
      compare();
      chk("rst_last_g_first", int'(m_tid), 0);
      do_reset();

      // 1: src0, 8 aligned beats
      log_q.delete();
      pev_seen = 0;
      push_pkt(0, 8, 8'h01, 1'b0);
      drain(200);
      chk("t1_len", log_q.size(), 8);
      for (int j = 0; j < 8; j++) chk_log("t1", j, 0, (j == 7), j + 1);
      chk("t1_pad_events", pev_seen, 0);
      chk("t1_pad_total", int'(pad_total), 0);

      // 2: src1, 5 beats -> 3 pad beats
      log_q.delete();
      pev_seen = 0;
      push_pkt(1, 5, 8'h11, 1'b0);
      drain(200);
      chk("t2_len", log_q.size(), 8);
      for (int j = 0; j < 5; j++) chk_log("t2", j, 1, 1'b0, 8'h11 + j);
      for (int j = 5; j < 8; j++) chk_log("t2pad", j, 1, (j == 7), 8'hA5);
      chk("t2_pad_events", pev_seen, 1);
      chk("t2_pad_total", int'(pad_total), 3);

      // 3: all sources busy, round-robin from a fresh reset
      do_reset();
      log_q.delete();
      push_pkt(0, 4, 8'h01, 1'b0);
      push_pkt(0, 4, 8'h05, 1'b0);
      push_pkt(1, 4, 8'h21, 1'b0);
      push_pkt(2, 4, 8'h31, 1'b0);
      push_pkt(3, 4, 8'h41, 1'b0);
      drain(400);
      exp3 = '{0, 1, 2, 3, 0};
      p = 0;
      start = 1'b1;
      foreach (log_q[j]) begin
         if (start) begin
            if (p < 5) chk("t3_grant", log_q[j].tid, exp3[p]);
            p++;
         end
         start = log_q[j].last;
      end
      chk("t3_pkts", p, 5);
      chk_log("t3_second_src0", 16, 0, 1'b0, 8'h05);

      // 4: toggling m_tready through PASS and PAD
      log_q.delete();
      rmode = 1;
      push_pkt(3, 6, 8'h61, 1'b0);
      drain(200);
      chk("t4_len", log_q.size(), 8);
      for (int j = 0; j < 6; j++) chk_log("t4", j, 3, 1'b0, 8'h61 + j);
      chk_log("t4pad", 7, 3, 1'b1, 8'hA5);
      chk("t4_pad_total", int'(pad_total), 2);
      rmode = 0;

      // 5: async reset mid-packet from src2
      push_pkt(2, 6, 8'h71, 1'b0);
      n = 0;
      while (srcq[2].size() > 4 && n < 50) begin
         step();
         n++;
      end
      chk("t5_reach_beat2", int'(srcq[2].size()), 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_tvalid", int'(m_tvalid), 0);
      chk("t5_rst_tready", int'(s_tready), 0);
      chk("t5_rst_tlast", int'(m_tlast), 0);
      chk("t5_rst_tid", int'(m_tid), 0);
      chk("t5_rst_pad_total", int'(pad_total), 0);
      chk("t5_rst_pad_event", int'(pad_event), 0);
      model_reset();
      clear_src();
      repeat (2) step();
      rst_n = 1'b1;
      log_q.delete();
      push_pkt(2, 4, 8'h51, 1'b0);
      push_pkt(0, 4, 8'h41, 1'b0);
      drain(200);
      chk("t5_len", log_q.size(), 8);
      chk_log("t5_first", 0, 0, 1'b0, 8'h41);
      chk_log("t5_second", 4, 2, 1'b0, 8'h51);
      chk("t5_pad_total", int'(pad_total), 0);

      // 6: random sources, lengths, valid gaps and backpressure
      rmode = 2;
      vprob = 70;
      for (int k = 0; k < 60; k++) begin
         s = $urandom_range(0, NS - 1);
         push_pkt(s, $urandom_range(1, 10), 0, 1'b1);
      end
      drain(30000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
